// File: rtl/bp_cfg_cmd_endpoint.sv
// Per-tile config-link slave: decodes uncached cfg commands into config registers and the
// CCE microcode RAM port, and returns exactly one response per command.
module bp_cfg_cmd_endpoint #(
  parameter int paddr_width_p         = 40,
  parameter int cfg_addr_width_p      = 16,
  parameter int cfg_dev_width_p       = 4,
  parameter int cce_id_width_p        = 6,
  parameter int cfg_dev_p             = 2,
  parameter int dword_width_p         = 64,
  parameter int vaddr_width_p         = 39,
  parameter int inst_ram_addr_width_p = 8,
  parameter int inst_width_p          = 48
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [cce_id_width_p-1:0]        cce_id_i,

  input  logic                             cmd_v_i,
  output logic                             cmd_ready_o,
  input  logic                             cmd_wr_i,
  input  logic [paddr_width_p-1:0]         cmd_addr_i,
  input  logic [dword_width_p-1:0]         cmd_data_i,

  output logic                             resp_v_o,
  input  logic                             resp_yumi_i,
  output logic                             resp_wr_o,
  output logic [paddr_width_p-1:0]         resp_addr_o,
  output logic [dword_width_p-1:0]         resp_data_o,

  output logic                             reset_o,
  output logic                             freeze_o,
  output logic                             icache_mode_o,
  output logic                             dcache_mode_o,
  output logic                             cce_mode_o,
  output logic [vaddr_width_p-1:0]         npc_o,
  output logic                             npc_w_v_o,

  output logic                             ucode_v_o,
  output logic                             ucode_w_o,
  output logic [inst_ram_addr_width_p-1:0] ucode_addr_o,
  output logic [inst_width_p-1:0]          ucode_data_o,
  input  logic [inst_width_p-1:0]          ucode_data_i
);

  localparam int DevLsb = cfg_addr_width_p;
  localparam int CceLsb = cfg_addr_width_p + cfg_dev_width_p;
  localparam int NlLsb  = cfg_addr_width_p + cfg_dev_width_p + cce_id_width_p;
  localparam logic [31:0] RamBase = 32'h8000;
  localparam logic [31:0] RamEnd  = RamBase + (32'd1 << inst_ram_addr_width_p);

  typedef enum logic [1:0] {READY, UCODE_RD, RESP} state_e;

  state_e                        state_q;
  logic                          accept;
  logic                          hit;
  logic                          ram_hit;
  logic [cfg_addr_width_p-1:0]   a;
  logic [31:0]                   a_ext;
  logic [dword_width_p-1:0]      rd_data;
  logic                          resp_wr_q;
  logic [paddr_width_p-1:0]      resp_addr_q;
  logic [dword_width_p-1:0]      resp_data_q;
  logic                          unused_data;

  assign a     = cmd_addr_i[cfg_addr_width_p-1:0];
  assign a_ext = 32'(a);
  assign hit   = (cmd_addr_i[paddr_width_p-1:NlLsb] == '0)
              && (cmd_addr_i[NlLsb-1:CceLsb] == cce_id_i)
              && (cmd_addr_i[CceLsb-1:DevLsb] == cfg_dev_width_p'(cfg_dev_p));
  assign ram_hit = (a_ext >= RamBase) && (a_ext < RamEnd);

  // Gating with the reset pin keeps the accept path quiet while reset is held.
  assign cmd_ready_o = reset_n_i && (state_q == READY);
  assign accept      = cmd_v_i && cmd_ready_o;

  assign ucode_v_o    = accept && hit && ram_hit;
  assign ucode_w_o    = ucode_v_o && cmd_wr_i;
  assign ucode_addr_o = a[inst_ram_addr_width_p-1:0];
  assign ucode_data_o = cmd_data_i[inst_width_p-1:0];
  assign unused_data  = ^cmd_data_i[dword_width_p-1:inst_width_p];

  assign resp_v_o    = (state_q == RESP);
  assign resp_wr_o   = resp_wr_q;
  assign resp_addr_o = resp_addr_q;
  assign resp_data_o = resp_data_q;

  always_comb begin
    rd_data = '0;
    if (hit && !cmd_wr_i) begin
      case (a)
        16'h0001: rd_data = dword_width_p'(freeze_o);
        16'h0002: rd_data = dword_width_p'(reset_o);
        16'h0003: rd_data = dword_width_p'(icache_mode_o);
        16'h0004: rd_data = dword_width_p'(dcache_mode_o);
        16'h0005: rd_data = dword_width_p'(cce_mode_o);
        16'h0006: rd_data = dword_width_p'(npc_o);
        default:  rd_data = '0;
      endcase
    end
  end

  // Control: FSM and configuration registers; register writes commit on the accept edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= READY;
      reset_o       <= 1'b1;
      freeze_o      <= 1'b1;
      icache_mode_o <= 1'b0;
      dcache_mode_o <= 1'b0;
      cce_mode_o    <= 1'b0;
      npc_o         <= '0;
      npc_w_v_o     <= 1'b0;
    end else begin
      npc_w_v_o <= 1'b0;
      case (state_q)
        READY: begin
          if (accept) begin
            if (hit && cmd_wr_i) begin
              case (a)
                16'h0001: freeze_o      <= cmd_data_i[0];
                16'h0002: reset_o       <= cmd_data_i[0];
                16'h0003: icache_mode_o <= cmd_data_i[0];
                16'h0004: dcache_mode_o <= cmd_data_i[0];
                16'h0005: cce_mode_o    <= cmd_data_i[0];
                16'h0006: begin
                  npc_o     <= cmd_data_i[vaddr_width_p-1:0];
                  npc_w_v_o <= 1'b1;
                end
                default: ;
              endcase
            end
            state_q <= (hit && ram_hit && !cmd_wr_i) ? UCODE_RD : RESP;
          end
        end
        UCODE_RD: state_q <= RESP;
        RESP:     if (resp_yumi_i) state_q <= READY;
        default:  state_q <= READY;
      endcase
    end
  end

  // Response payload: datapath only, qualified by resp_v_o.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      resp_wr_q   <= cmd_wr_i;
      resp_addr_q <= cmd_addr_i;
      resp_data_q <= rd_data;
    end else if (state_q == UCODE_RD) begin
      resp_data_q <= dword_width_p'(ucode_data_i);
    end
  end

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   resp_yumi_i |-> resp_v_o);

endmodule

// File: tb/tb_bp_cfg_cmd_endpoint.sv
// Directed bench for bp_cfg_cmd_endpoint with a one-cycle-latency microcode RAM model.
module tb_bp_cfg_cmd_endpoint;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  cce_id;
  logic        cmd_v, cmd_ready, cmd_wr;
  logic [39:0] cmd_addr;
  logic [63:0] cmd_data;
  logic        resp_v, resp_yumi, resp_wr;
  logic [39:0] resp_addr;
  logic [63:0] resp_data;
  logic        reset_o, freeze_o, icache_mode, dcache_mode, cce_mode;
  logic [38:0] npc;
  logic        npc_w_v;
  logic        ucode_v, ucode_w;
  logic [7:0]  ucode_addr;
  logic [47:0] ucode_wdata, ucode_rdata;

  int total = 0;
  int bad   = 0;

  logic [47:0] ram [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ucode_v) begin
      if (ucode_w) ram[ucode_addr] <= ucode_wdata;
      else         ucode_rdata     <= ram[ucode_addr];
    end
  end

  bp_cfg_cmd_endpoint dut (
    .clk_i(clk), .reset_n_i(reset_n), .cce_id_i(cce_id),
    .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .resp_v_o(resp_v), .resp_yumi_i(resp_yumi), .resp_wr_o(resp_wr),
    .resp_addr_o(resp_addr), .resp_data_o(resp_data),
    .reset_o(reset_o), .freeze_o(freeze_o), .icache_mode_o(icache_mode),
    .dcache_mode_o(dcache_mode), .cce_mode_o(cce_mode),
    .npc_o(npc), .npc_w_v_o(npc_w_v),
    .ucode_v_o(ucode_v), .ucode_w_o(ucode_w), .ucode_addr_o(ucode_addr),
    .ucode_data_o(ucode_wdata), .ucode_data_i(ucode_rdata)
  );

  function automatic logic [39:0] mk_addr(input logic [13:0] nl, input logic [5:0] cce,
                                          input logic [3:0] dev, input logic [15:0] a);
    return {nl, cce, dev, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one cycle; returns 1 time unit after the accept edge.
  task automatic send(input logic wr, input logic [39:0] addr, input logic [63:0] data);
    cmd_v = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_data = data;
    tick();
    cmd_v = 1'b0; cmd_data = '0;
  endtask

  task automatic consume();
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    total++; if (reset_o !== 1'b1) begin bad++; $display("FAIL reset_reset_o got=%b exp=1", reset_o); end
    total++; if (freeze_o !== 1'b1) begin bad++; $display("FAIL reset_freeze got=%b exp=1", freeze_o); end
    total++; if (npc !== 39'd0) begin bad++; $display("FAIL reset_npc got=%h exp=0", npc); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (resp_v !== 1'b0) begin bad++; $display("FAIL reset_resp_v got=%b exp=0", resp_v); end
    total++; if ({icache_mode, dcache_mode, cce_mode, npc_w_v, ucode_v} !== 5'b0) begin
      bad++; $display("FAIL reset_modes got=%b exp=00000", {icache_mode, dcache_mode, cce_mode, npc_w_v, ucode_v});
    end
  endtask

  task automatic test_write_reset();
    logic [39:0] addr;
    addr = mk_addr(14'd0, 6'd5, 4'd2, 16'h0002);
    send(1'b1, addr, 64'd0);
    total++; if (reset_o !== 1'b0) begin bad++; $display("FAIL wr_reset_reset_o got=%b exp=0", reset_o); end
    total++; if (resp_v !== 1'b1) begin bad++; $display("FAIL wr_reset_resp_v got=%b exp=1", resp_v); end
    total++; if (resp_data !== 64'd0) begin bad++; $display("FAIL wr_reset_data got=%h exp=0", resp_data); end
    total++; if (resp_wr !== 1'b1) begin bad++; $display("FAIL wr_reset_resp_wr got=%b exp=1", resp_wr); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (resp_v !== 1'b1 || cmd_ready !== 1'b0 || resp_addr !== addr) begin
        bad++; $display("FAIL hold_resp cyc=%0d got v=%b rdy=%b addr=%h exp v=1 rdy=0 addr=%h",
                        i, resp_v, cmd_ready, resp_addr, addr);
      end
    end
    consume();
    total++; if (resp_v !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL after_yumi got v=%b rdy=%b exp v=0 rdy=1", resp_v, cmd_ready);
    end
  endtask

  task automatic test_npc();
    send(1'b1, mk_addr(14'd0, 6'd5, 4'd2, 16'h0006), 64'hFFFF_FF00_8000_0000);
    total++; if (npc_w_v !== 1'b1) begin bad++; $display("FAIL npc_w_v_pulse got=%b exp=1", npc_w_v); end
    total++; if (npc !== 39'h00_8000_0000) begin bad++; $display("FAIL npc_value got=%h exp=0080000000", npc); end
    consume();
    total++; if (npc_w_v !== 1'b0) begin bad++; $display("FAIL npc_w_v_clear got=%b exp=0", npc_w_v); end
    send(1'b0, mk_addr(14'd0, 6'd5, 4'd2, 16'h0006), 64'd0);
    total++; if (resp_v !== 1'b1 || resp_data !== 64'h0000_0000_8000_0000) begin
      bad++; $display("FAIL npc_read got v=%b data=%h exp v=1 data=0000000080000000", resp_v, resp_data);
    end
    total++; if (npc_w_v !== 1'b0) begin bad++; $display("FAIL npc_read_no_pulse got=%b exp=0", npc_w_v); end
    consume();
  endtask

  task automatic test_ucode();
    cmd_v = 1'b1; cmd_wr = 1'b1;
    cmd_addr = mk_addr(14'd0, 6'd5, 4'd2, 16'h8003);
    cmd_data = 64'h5555_ABCD_1234_5678;
    #1;
    total++; if (ucode_v !== 1'b1 || ucode_w !== 1'b1 || ucode_addr !== 8'd3 || ucode_wdata !== 48'hABCD_1234_5678) begin
      bad++; $display("FAIL ucode_wr_strobe got v=%b w=%b a=%h d=%h exp v=1 w=1 a=03 d=abcd12345678",
                      ucode_v, ucode_w, ucode_addr, ucode_wdata);
    end
    tick();
    cmd_v = 1'b0;
    total++; if (resp_v !== 1'b1 || resp_data !== 64'd0) begin
      bad++; $display("FAIL ucode_wr_resp got v=%b data=%h exp v=1 data=0", resp_v, resp_data);
    end
    consume();
    cmd_v = 1'b1; cmd_wr = 1'b0; cmd_data = '0;
    #1;
    total++; if (ucode_v !== 1'b1 || ucode_w !== 1'b0 || ucode_addr !== 8'd3) begin
      bad++; $display("FAIL ucode_rd_strobe got v=%b w=%b a=%h exp v=1 w=0 a=03", ucode_v, ucode_w, ucode_addr);
    end
    tick();
    cmd_v = 1'b0;
    total++; if (resp_v !== 1'b0) begin bad++; $display("FAIL ucode_rd_lat1 got=%b exp=0", resp_v); end
    tick();
    total++; if (resp_v !== 1'b1 || resp_data !== 64'h0000_ABCD_1234_5678) begin
      bad++; $display("FAIL ucode_rd_data got v=%b data=%h exp v=1 data=0000abcd12345678", resp_v, resp_data);
    end
    consume();
  endtask

  task automatic test_miss();
    send(1'b1, mk_addr(14'd0, 6'd6, 4'd2, 16'h0001), 64'd0);
    total++; if (freeze_o !== 1'b1) begin bad++; $display("FAIL miss_cce_freeze got=%b exp=1", freeze_o); end
    total++; if (resp_v !== 1'b1 || resp_data !== 64'd0) begin
      bad++; $display("FAIL miss_cce_resp got v=%b data=%h exp v=1 data=0", resp_v, resp_data);
    end
    consume();
    send(1'b0, mk_addr(14'd1, 6'd5, 4'd2, 16'h0001), 64'd0);
    total++; if (resp_data !== 64'd0) begin bad++; $display("FAIL miss_nonlocal_read got=%h exp=0", resp_data); end
    consume();
    send(1'b0, mk_addr(14'd0, 6'd5, 4'd3, 16'h0002), 64'd0);
    total++; if (resp_data !== 64'd0) begin bad++; $display("FAIL miss_dev_read got=%h exp=0", resp_data); end
    consume();
    send(1'b0, mk_addr(14'd0, 6'd5, 4'd2, 16'h0001), 64'd0);
    total++; if (resp_data !== 64'd1) begin bad++; $display("FAIL hit_freeze_read got=%h exp=1", resp_data); end
    consume();
    send(1'b0, mk_addr(14'd0, 6'd5, 4'd2, 16'h0007), 64'd0);
    total++; if (resp_data !== 64'd0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", resp_data); end
    consume();
  endtask

  task automatic test_back_to_back();
    send(1'b1, mk_addr(14'd0, 6'd5, 4'd2, 16'h0003), 64'hFF);
    consume();
    send(1'b1, mk_addr(14'd0, 6'd5, 4'd2, 16'h0005), 64'h3);
    total++; if (icache_mode !== 1'b1 || cce_mode !== 1'b1) begin
      bad++; $display("FAIL b2b_modes got ic=%b cce=%b exp ic=1 cce=1", icache_mode, cce_mode);
    end
    consume();
    send(1'b1, mk_addr(14'd0, 6'd5, 4'd2, 16'h0001), 64'hFE);
    total++; if (freeze_o !== 1'b0) begin bad++; $display("FAIL freeze_bit0 got=%b exp=0", freeze_o); end
    consume();
    send(1'b0, mk_addr(14'd0, 6'd5, 4'd2, 16'h0003), 64'd0);
    total++; if (resp_data !== 64'd1) begin bad++; $display("FAIL icache_read got=%h exp=1", resp_data); end
    consume();
  endtask

  task automatic test_reset_in_resp();
    send(1'b1, mk_addr(14'd0, 6'd5, 4'd2, 16'h0004), 64'd1);
    total++; if (resp_v !== 1'b1 || dcache_mode !== 1'b1) begin
      bad++; $display("FAIL pre_reset got v=%b dc=%b exp v=1 dc=1", resp_v, dcache_mode);
    end
    #2 reset_n = 1'b0;
    #1;
    total++; if (resp_v !== 1'b0) begin bad++; $display("FAIL async_resp_v got=%b exp=0", resp_v); end
    total++; if (reset_o !== 1'b1 || freeze_o !== 1'b1 || dcache_mode !== 1'b0 || npc !== 39'd0) begin
      bad++; $display("FAIL async_regs got rst=%b frz=%b dc=%b npc=%h exp rst=1 frz=1 dc=0 npc=0",
                      reset_o, freeze_o, dcache_mode, npc);
    end
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (cmd_ready !== 1'b1 || resp_v !== 1'b0) begin
      bad++; $display("FAIL post_reset got rdy=%b v=%b exp rdy=1 v=0", cmd_ready, resp_v);
    end
  endtask

  initial begin
    reset_n = 1'b0; cce_id = 6'd5;
    cmd_v = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = '0;
    resp_yumi = 1'b0; ucode_rdata = '0;
    test_reset();
    test_write_reset();
    test_npc();
    test_ucode();
    test_miss();
    test_back_to_back();
    test_reset_in_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
